memory_turn_ctrl: RTL and testbench

Turn sequencer for the two-player memory (pairs) game on a 16-card 4x4 board. It accepts card selections and enforces the two-picks-per-turn rule. It compares the revealed symbols, keeps per-player scores, runs the turn timeout and the mismatch display delay, and decides the winner. It sits between the input/cursor logic and the VGA board renderer, and owns the face-up and matched masks the renderer draws from.

---
 rtl/memory_turn_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_memory_turn_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_turn_ctrl.sv
// Turn sequencer for a two-player 4x4 memory (pairs) game: pick rule, pair
// check, scores, turn timeout, mismatch display delay and winner decision.
module memory_turn_ctrl #(
    parameter int TURN_TICKS = 15,
    parameter int SHOW_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tick,
    input  logic        sel,
    input  logic [3:0]  pos,
    input  logic [3:0]  sym,
    output logic        player,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic [3:0]  timer,
    output logic [2:0]  state_o,
    output logic        pair_pulse,
    output logic        game_over,
    output logic [1:0]  winner
);
    localparam int SW = (SHOW_TICKS < 2) ? 1 : $clog2(SHOW_TICKS + 1);
    localparam logic [3:0]    TURN_LD  = 4'(TURN_TICKS);
    localparam logic [SW-1:0] SHOW_LD  = SW'(SHOW_TICKS);
    localparam logic [SW-1:0] SHOW_ONE = SW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK1 = 3'd1,
        PICK2 = 3'd2,
        CHECK = 3'd3,
        SHOW  = 3'd4,
        HIDE  = 3'd5,
        OVER  = 3'd6
    } state_t;

    state_t        state, state_n;
    logic          player_n, pulse_n, over_n;
    logic [15:0]   face_n, matched_n;
    logic [3:0]    s1_n, s2_n, timer_n;
    logic [3:0]    pos1, pos2, sym1, sym2;
    logic [3:0]    pos1_n, pos2_n, sym1_n, sym2_n;
    logic [SW-1:0] show_cnt, show_n;
    logic [1:0]    winner_n;
    logic [4:0]    total;
    logic          valid_sel;

    assign state_o   = state;
    assign valid_sel = sel && (state == PICK1 || state == PICK2) &&
                       !matched[pos] && !face_up[pos];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            player     <= 1'b0;
            face_up    <= '0;
            matched    <= '0;
            score1     <= '0;
            score2     <= '0;
            timer      <= '0;
            pos1       <= '0;
            pos2       <= '0;
            sym1       <= '0;
            sym2       <= '0;
            show_cnt   <= '0;
            pair_pulse <= 1'b0;
            game_over  <= 1'b0;
            winner     <= '0;
        end else begin
            state      <= state_n;
            player     <= player_n;
            face_up    <= face_n;
            matched    <= matched_n;
            score1     <= s1_n;
            score2     <= s2_n;
            timer      <= timer_n;
            pos1       <= pos1_n;
            pos2       <= pos2_n;
            sym1       <= sym1_n;
            sym2       <= sym2_n;
            show_cnt   <= show_n;
            pair_pulse <= pulse_n;
            game_over  <= over_n;
            winner     <= winner_n;
        end
    end

    always_comb begin
        state_n   = state;
        player_n  = player;
        face_n    = face_up;
        matched_n = matched;
        s1_n      = score1;
        s2_n      = score2;
        timer_n   = timer;
        pos1_n    = pos1;
        pos2_n    = pos2;
        sym1_n    = sym1;
        sym2_n    = sym2;
        show_n    = show_cnt;
        pulse_n   = 1'b0;
        winner_n  = winner;
        total     = '0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    face_n    = '0;
                    matched_n = '0;
                    s1_n      = '0;
                    s2_n      = '0;
                    player_n  = 1'b0;
                    timer_n   = TURN_LD;
                    winner_n  = '0;
                    state_n   = PICK1;
                end
            end
            PICK1, PICK2: begin
                // An accepted selection swallows a coincident tick
                if (valid_sel) begin
                    face_n[pos] = 1'b1;
                    if (state == PICK1) begin
                        pos1_n  = pos;
                        sym1_n  = sym;
                        timer_n = TURN_LD;
                        state_n = PICK2;
                    end else begin
                        pos2_n  = pos;
                        sym2_n  = sym;
                        state_n = CHECK;
                    end
                end else if (tick && timer != '0) begin
                    timer_n = timer - 4'd1;
                    if (timer == 4'd1) begin
                        if (state == PICK2)
                            face_n[pos1] = 1'b0;
                        player_n = ~player;
                        timer_n  = TURN_LD;
                        state_n  = PICK1;
                    end
                end
            end
            CHECK: begin
                if (sym1 == sym2) begin
                    face_n[pos1]    = 1'b0;
                    face_n[pos2]    = 1'b0;
                    matched_n[pos1] = 1'b1;
                    matched_n[pos2] = 1'b1;
                    if (player)
                        s2_n = score2 + 4'd1;
                    else
                        s1_n = score1 + 4'd1;
                    pulse_n = 1'b1;
                    total   = {1'b0, s1_n} + {1'b0, s2_n};
                    if (total == 5'd8) begin
                        state_n  = OVER;
                        winner_n = (s1_n > s2_n) ? 2'b01 :
                                   (s2_n > s1_n) ? 2'b10 : 2'b11;
                    end else begin
                        timer_n = TURN_LD;
                        state_n = PICK1;
                    end
                end else begin
                    show_n  = SHOW_LD;
                    state_n = SHOW;
                end
            end
            SHOW: begin
                if (show_cnt == '0) begin
                    state_n = HIDE;
                end else if (tick) begin
                    show_n = show_cnt - SHOW_ONE;
                    if (show_cnt == SHOW_ONE)
                        state_n = HIDE;
                end
            end
            HIDE: begin
                face_n[pos1] = 1'b0;
                face_n[pos2] = 1'b0;
                player_n     = ~player;
                timer_n      = TURN_LD;
                state_n      = PICK1;
            end
            default: state_n = IDLE;
        endcase
        over_n = (state_n == OVER);
    end
endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Bench for memory_turn_ctrl: directed game scenarios checked every cycle
// against a card-level game model, plus hand-computed literal expectations.
module tb_memory_turn_ctrl;
    localparam int TURN = 15;
    localparam int SHOWT = 2;

    logic        clk = 1'b0;
    logic        rst, start, tick, sel;
    logic [3:0]  pos, sym;
    logic        player, pair_pulse, game_over;
    logic [15:0] face_up, matched;
    logic [3:0]  score1, score2, timer;
    logic [2:0]  state_o;
    logic [1:0]  winner;

    logic [3:0]  board [16];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;

    memory_turn_ctrl #(.TURN_TICKS(TURN), .SHOW_TICKS(SHOWT)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .sel(sel),
        .pos(pos), .sym(sym), .player(player), .face_up(face_up),
        .matched(matched), .score1(score1), .score2(score2), .timer(timer),
        .state_o(state_o), .pair_pulse(pair_pulse), .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;
    assign sym = board[pos];

    // Game model: phase codes are the externally visible state numbers
    int       ph, pl, tmr, s1, s2, p1, p2, y1, y2, showc, win;
    bit [15:0] up, done;
    bit       mpulse;

    always @(posedge clk) begin
        bit pulse;
        pulse = 1'b0;
        if (!rst) begin
            ph = 0; pl = 0; tmr = 0; s1 = 0; s2 = 0; p1 = 0; p2 = 0;
            y1 = 0; y2 = 0; showc = 0; win = 0; up = '0; done = '0;
        end else begin
            case (ph)
                0, 6: if (start) begin
                    up = '0; done = '0; s1 = 0; s2 = 0; pl = 0;
                    tmr = TURN; win = 0; ph = 1;
                end
                1, 2: if (sel && !up[pos] && !done[pos]) begin
                    up[pos] = 1'b1;
                    if (ph == 1) begin p1 = pos; y1 = sym; tmr = TURN; ph = 2; end
                    else begin p2 = pos; y2 = sym; ph = 3; end
                end else if (tick && tmr > 0) begin
                    tmr = tmr - 1;
                    if (tmr == 0) begin
                        if (ph == 2) up[p1] = 1'b0;
                        pl = 1 - pl; tmr = TURN; ph = 1;
                    end
                end
                3: if (y1 == y2) begin
                    up[p1] = 1'b0; up[p2] = 1'b0;
                    done[p1] = 1'b1; done[p2] = 1'b1;
                    if (pl == 1) s2 = s2 + 1; else s1 = s1 + 1;
                    pulse = 1'b1;
                    if (s1 + s2 == 8) begin
                        ph = 6;
                        win = (s1 > s2) ? 1 : (s2 > s1) ? 2 : 3;
                    end else begin
                        tmr = TURN; ph = 1;
                    end
                end else begin
                    showc = SHOWT; ph = 4;
                end
                4: if (tick) begin
                    showc = showc - 1;
                    if (showc == 0) ph = 5;
                end
                5: begin
                    up[p1] = 1'b0; up[p2] = 1'b0;
                    pl = 1 - pl; tmr = TURN; ph = 1;
                end
                default: ph = 0;
            endcase
        end
        mpulse = pulse;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state_o",    32'(state_o),    32'(ph));
            chk("player",     32'(player),     32'(pl));
            chk("face_up",    32'(face_up),    32'(up));
            chk("matched",    32'(matched),    32'(done));
            chk("score1",     32'(score1),     32'(s1));
            chk("score2",     32'(score2),     32'(s2));
            chk("timer",      32'(timer),      32'(tmr));
            chk("pair_pulse", 32'(pair_pulse), 32'(mpulse));
            chk("game_over",  32'(game_over),  32'(ph == 6));
            chk("winner",     32'(winner),     32'(win));
        end
    end

    // One clock cycle of stimulus, entered and left on a falling edge
    task automatic cyc(input bit st, input bit tk, input bit sl, input logic [3:0] p);
        start = st; tick = tk; sel = sl; pos = p;
        @(negedge clk);
        start = 1'b0; tick = 1'b0; sel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0);
    endtask

    task automatic pick(input logic [3:0] p);
        cyc(0, 0, 1, p);
    endtask

    task automatic pair(input logic [3:0] a, input logic [3:0] b);
        pick(a); pick(b); idle(1);
    endtask

    task automatic miss(input logic [3:0] a, input logic [3:0] b);
        pick(a); pick(b); idle(1);
        cyc(0, 1, 0, 4'd0); cyc(0, 1, 0, 4'd0);
        idle(1);
    endtask

    initial begin
        automatic logic [3:0] syms [16] = '{4'd5, 4'd0, 4'd3, 4'd1, 4'd7, 4'd0, 4'd2, 4'd4,
                                            4'd6, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
        board = syms;
        rst = 1'b0; start = 1'b0; tick = 1'b0; sel = 1'b0; pos = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset state", 32'(state_o), 32'd0);
        chk("reset timer", 32'(timer), 32'd0);
        chk("reset winner", 32'(winner), 32'd0);
        rst = 1'b1;
        idle(1);

        // Reset in the middle of a mismatch display
        cyc(1, 0, 0, 4'd0);
        pick(4'd0); pick(4'd1); idle(1);
        chk("pre-reset state", 32'(state_o), 32'd4);
        chk("pre-reset face_up", 32'(face_up), 32'h0003);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid-show reset state", 32'(state_o), 32'd0);
        chk("mid-show reset face_up", 32'(face_up), 32'h0000);
        chk("mid-show reset player", 32'(player), 32'd0);

        // First pair matched by P1
        cyc(1, 0, 0, 4'd0);
        pick(4'd0); pick(4'd9);
        chk("check state", 32'(state_o), 32'd3);
        idle(1);
        chk("match matched", 32'(matched), 32'h0201);
        chk("match score1", 32'(score1), 32'd1);
        chk("match pulse", 32'(pair_pulse), 32'd1);
        chk("match timer", 32'(timer), 32'd15);
        idle(1);
        chk("pulse one cycle", 32'(pair_pulse), 32'd0);

        // Mismatch shown for two ticks then hidden, turn passes to P2
        pick(4'd2); pick(4'd4); idle(1);
        chk("show face_up", 32'(face_up), 32'h0014);
        cyc(0, 1, 0, 4'd0);
        chk("show after 1 tick", 32'(face_up), 32'h0014);
        cyc(0, 1, 0, 4'd0);
        chk("hide state", 32'(state_o), 32'd5);
        idle(1);
        chk("hidden face_up", 32'(face_up), 32'h0000);
        chk("hidden player", 32'(player), 32'd1);

        // Ignored selections: same card, matched card
        pick(4'd3); pick(4'd3); pick(4'd0);
        chk("ignored sel state", 32'(state_o), 32'd2);
        chk("ignored sel face_up", 32'(face_up), 32'h0008);

        // Timer at 1 in PICK2: valid sel beats the tick
        repeat (14) cyc(0, 1, 0, 4'd0);
        chk("timer near expiry", 32'(timer), 32'd1);
        cyc(0, 1, 1, 4'd5);
        chk("sel wins state", 32'(state_o), 32'd3);
        chk("sel wins player", 32'(player), 32'd1);
        chk("sel wins timer", 32'(timer), 32'd1);
        idle(1);
        cyc(0, 1, 0, 4'd0); cyc(0, 1, 0, 4'd0); idle(1);
        chk("back to P1", 32'(player), 32'd0);

        // Same setup with tick only: turn times out (invalid sel must not block ticks)
        pick(4'd3);
        cyc(0, 1, 1, 4'd0);
        repeat (13) cyc(0, 1, 0, 4'd0);
        chk("timeout setup timer", 32'(timer), 32'd1);
        cyc(0, 1, 0, 4'd0);
        chk("timeout face_up", 32'(face_up), 32'h0000);
        chk("timeout player", 32'(player), 32'd1);
        chk("timeout state", 32'(state_o), 32'd1);
        chk("timeout timer", 32'(timer), 32'd15);

        // Finish the board at 4-4
        pair(4'd1, 4'd5); pair(4'd3, 4'd10); pair(4'd6, 4'd11); pair(4'd2, 4'd12);
        miss(4'd7, 4'd8);
        pair(4'd7, 4'd13); pair(4'd8, 4'd14); pair(4'd4, 4'd15);
        chk("over state", 32'(state_o), 32'd6);
        chk("over game_over", 32'(game_over), 32'd1);
        chk("over winner", 32'(winner), 32'd3);
        chk("over matched", 32'(matched), 32'hFFFF);
        chk("over score2", 32'(score2), 32'd4);
        pick(4'd0);
        cyc(0, 1, 0, 4'd0);
        chk("over holds", 32'(state_o), 32'd6);
        cyc(1, 0, 0, 4'd0);
        chk("restart state", 32'(state_o), 32'd1);
        chk("restart score1", 32'(score1), 32'd0);
        chk("restart matched", 32'(matched), 32'h0000);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
